// File: rtl/jstk_pkg.sv
// Shared constants and helpers for the joystick decoder.
// Holds the FSM state encoding, the LED command prefix, the joystick
// centre value and the paddle reset position so the top level, the
// paddle integrator and any future SPI-side logic agree on them.
package jstk_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRIG  = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;

   // The top bit of the first command byte is always set; the low two
   // bits carry the LED state.
   localparam logic [7:0] LED_CMD_PREFIX = 8'h80;

   // Axis value reported by a centred stick
   localparam logic [9:0] JOY_CENTRE = 10'd512;

   // Paddle position after reset and while the stick button is held
   localparam logic [8:0] PAD_RESET = 9'd210;

   // One decoded joystick frame
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] btn;
   } jstk_frame_t;

   // Pull X, Y and the buttons out of the 40-bit receive word. The
   // first byte on the wire lands in [39:32].
   function automatic jstk_frame_t decode_frame(input logic [39:0] rx);
      jstk_frame_t f;
      f.x   = {rx[25:24], rx[39:32]};
      f.y   = {rx[9:8],   rx[23:16]};
      f.btn = rx[2:0];
      return f;
   endfunction

   // Bits that a well-formed frame always drives to zero
   function automatic logic frame_malformed(input logic [39:0] rx);
      return (|rx[31:26]) | (|rx[15:10]) | (|rx[7:3]);
   endfunction

   // First command byte for a given LED state
   function automatic logic [7:0] led_command(input logic [1:0] leds);
      return LED_CMD_PREFIX | {6'b0, leds};
   endfunction

endpackage

// File: rtl/joystick_decoder_paddle_integrator.sv
// Saturating paddle position integrator.
// Moves the paddle by PAD_STEP when the Y axis leaves the centre band,
// clamps the result to [0, PAD_MAX], and snaps to the centre position
// while the stick button is held. Updates only on step_en.
module paddle_integrator
   import jstk_pkg::*;
#(
   parameter int DEAD_ZONE = 64,
   parameter int PAD_MAX   = 420,
   parameter int PAD_STEP  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] y,
   input  logic       step_en,
   input  logic       centre_force,
   output logic [8:0] pad_pos
);

   // Eleven bits of headroom so neither the add nor the band limits
   // can wrap before the clamp is applied.
   localparam logic [10:0] UP_LIMIT  = 11'(JOY_CENTRE) + 11'(DEAD_ZONE);
   localparam logic [10:0] LOW_LIMIT = 11'(JOY_CENTRE) - 11'(DEAD_ZONE);
   localparam logic [10:0] STEP_EXT  = 11'(PAD_STEP);
   localparam logic [10:0] MAX_EXT   = 11'(PAD_MAX);

   logic [8:0]  pad_pos_q;
   logic [8:0]  pad_pos_d;
   logic [10:0] y_ext;
   logic [10:0] pos_ext;
   logic [10:0] pos_up;
   logic [10:0] pos_down;
   logic [10:0] pos_next;

   assign y_ext   = {1'b0, y};
   assign pos_ext = {2'b0, pad_pos_q};

   // Work out the saturated candidate positions and pick the next one
   always_comb begin
      pos_up   = pos_ext + STEP_EXT;
      if (pos_up > MAX_EXT) begin
         pos_up = MAX_EXT;
      end

      if (pos_ext < STEP_EXT) begin
         pos_down = 11'd0;
      end else begin
         pos_down = pos_ext - STEP_EXT;
      end
      if (pos_down > MAX_EXT) begin
         pos_down = MAX_EXT;
      end

      pos_next = pos_ext;
      if (centre_force) begin
         pos_next = {2'b0, PAD_RESET};
      end else if (y_ext > UP_LIMIT) begin
         pos_next = pos_up;
      end else if (y_ext < LOW_LIMIT) begin
         pos_next = pos_down;
      end

      pad_pos_d = pad_pos_q;
      if (step_en) begin
         pad_pos_d = pos_next[8:0];
      end
   end

   // Paddle position register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_pos_q <= PAD_RESET;
      end else begin
         pad_pos_q <= pad_pos_d;
      end
   end

   assign pad_pos = pad_pos_q;

endmodule

// File: rtl/joystick_decoder.sv
// Joystick frame poller and decoder.
// Periodically asks the external SPI master for a 40-bit transfer,
// waits for it to finish, then checks and decodes the received frame
// into joystick axes, buttons and an integrated paddle position.
module joystick_decoder
   import jstk_pkg::*;
#(
   parameter int POLL_CYCLES = 1_000_000,
   parameter int XFER_CYCLES = 3000,
   parameter int DEAD_ZONE   = 64,
   parameter int PAD_MAX     = 420,
   parameter int PAD_STEP    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        spi_trigger,
   output logic [39:0] spi_tx,
   input  logic [39:0] spi_rx,
   input  logic [1:0]  leds,
   output logic [9:0]  joy_x,
   output logic [9:0]  joy_y,
   output logic [2:0]  buttons,
   output logic [8:0]  pad_pos,
   output logic        sample_valid,
   output logic        frame_err
);

   localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
   localparam logic [31:0] XFER_LAST = 32'(XFER_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [9:0]  joy_x_q, joy_x_d;
   logic [9:0]  joy_y_q, joy_y_d;
   logic [2:0]  buttons_q, buttons_d;
   logic        sample_valid_q, sample_valid_d;
   logic        frame_err_q, frame_err_d;

   jstk_frame_t frame;
   logic        in_latch;
   logic        bad_frame;
   logic        accept;

   // The command word only depends on the LED inputs, so the SPI master
   // can shift it out at any time without a handshake.
   assign spi_tx = {led_command(leds), 32'h0};

   // Sequencing: wait out the poll interval, fire one trigger, let the
   // transfer complete, then spend one cycle sampling the result.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q == POLL_LAST) begin
               state_d = ST_TRIG;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_TRIG: begin
            state_d = ST_WAIT;
            cnt_d   = 32'd0;
         end
         ST_WAIT: begin
            if (cnt_q == XFER_LAST) begin
               state_d = ST_LATCH;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign spi_trigger = (state_q == ST_TRIG);

   // spi_rx is only looked at during LATCH; outside it the decode
   // results are ignored by everything downstream.
   assign in_latch  = (state_q == ST_LATCH);
   assign frame     = decode_frame(spi_rx);
   assign bad_frame = frame_malformed(spi_rx);
   assign accept    = in_latch & ~bad_frame;

   // Output register updates: good frames refresh the outputs and pulse
   // sample_valid, bad frames only raise the sticky error flag.
   always_comb begin
      joy_x_d        = joy_x_q;
      joy_y_d        = joy_y_q;
      buttons_d      = buttons_q;
      sample_valid_d = accept;
      frame_err_d    = frame_err_q | (in_latch & bad_frame);
      if (accept) begin
         joy_x_d   = frame.x;
         joy_y_d   = frame.y;
         buttons_d = frame.btn;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         joy_x_q        <= JOY_CENTRE;
         joy_y_q        <= JOY_CENTRE;
         buttons_q      <= 3'b000;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         joy_x_q        <= joy_x_d;
         joy_y_q        <= joy_y_d;
         buttons_q      <= buttons_d;
         sample_valid_q <= sample_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   // The paddle steps on the same edge that raises sample_valid
   paddle_integrator #(
      .DEAD_ZONE (DEAD_ZONE),
      .PAD_MAX   (PAD_MAX),
      .PAD_STEP  (PAD_STEP)
   ) u_paddle (
      .clk          (clk),
      .rst_n        (rst_n),
      .y            (frame.y),
      .step_en      (accept),
      .centre_force (frame.btn[0]),
      .pad_pos      (pad_pos)
   );

   assign joy_x        = joy_x_q;
   assign joy_y        = joy_y_q;
   assign buttons      = buttons_q;
   assign sample_valid = sample_valid_q;
   assign frame_err    = frame_err_q;

endmodule
